// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// drives all datapath enables and selects, and counts retired instructions.
module multicycle_ctrl #(
    parameter int unsigned CNT_W           = 32,
    parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       func,
    input  logic             zero,
    input  logic             mem_ready,
    output logic [3:0]       state,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       npc_sel,
    output logic             reg_we,
    output logic [1:0]       reg_dst,
    output logic [1:0]       wd_sel,
    output logic             alu_src,
    output logic [2:0]       alu_ctrl,
    output logic             ext_sign,
    output logic             mem_re,
    output logic             mem_we,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXE_R    = 4'd2,
        EXE_I    = 4'd3,
        WB_ALU   = 4'd4,
        MEM_ADDR = 4'd5,
        MEM_RD   = 4'd6,
        WB_MEM   = 4'd7,
        MEM_WR   = 4'd8,
        BR       = 4'd9,
        JMP      = 4'd10,
        HALT     = 4'd11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    state_t cur, nxt;
    logic   is_r, is_addu, is_subu, is_jr, is_nop;
    logic   is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal;
    logic   retire;

    always_comb begin
        is_r    = (op == 6'b000000);
        is_addu = is_r && (func == 6'b100001);
        is_subu = is_r && (func == 6'b100011);
        is_jr   = is_r && (func == 6'b001000);
        is_nop  = is_r && (func == 6'b000000);
        is_ori  = (op == 6'b001101);
        is_lui  = (op == 6'b001111);
        is_lw   = (op == 6'b100011);
        is_sw   = (op == 6'b101011);
        is_beq  = (op == 6'b000100);
        is_j    = (op == 6'b000010);
        is_jal  = (op == 6'b000011);
    end

    always_comb begin
        nxt = cur;
        case (cur)
            FETCH:    nxt = DECODE;
            DECODE: begin
                if (is_addu || is_subu)          nxt = EXE_R;
                else if (is_ori || is_lui)       nxt = EXE_I;
                else if (is_lw || is_sw)         nxt = MEM_ADDR;
                else if (is_beq)                 nxt = BR;
                else if (is_j || is_jal || is_jr) nxt = JMP;
                else if (is_nop)                 nxt = FETCH;
                else                             nxt = HALT_ON_ILLEGAL ? HALT : FETCH;
            end
            EXE_R, EXE_I:            nxt = WB_ALU;
            WB_ALU, WB_MEM, BR, JMP: nxt = FETCH;
            MEM_ADDR: nxt = is_lw ? MEM_RD : MEM_WR;
            MEM_RD:   nxt = mem_ready ? WB_MEM : MEM_RD;
            MEM_WR:   nxt = mem_ready ? FETCH : MEM_WR;
            HALT:     nxt = HALT;
            default:  nxt = FETCH;
        endcase
    end

    // Any transition into FETCH from another state completes an instruction.
    assign retire = (nxt == FETCH) && (cur != FETCH);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur       <= FETCH;
            instr_cnt <= '0;
        end else begin
            cur <= nxt;
            if (retire) instr_cnt <= instr_cnt + CNT_ONE;
        end
    end

    assign state = cur;

    always_comb begin
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        npc_sel  = 2'b00;
        reg_we   = 1'b0;
        reg_dst  = 2'b00;
        wd_sel   = 2'b00;
        alu_src  = 1'b0;
        alu_ctrl = 3'b000;
        ext_sign = 1'b1;
        mem_re   = 1'b0;
        mem_we   = 1'b0;
        illegal  = 1'b0;
        case (cur)
            FETCH: begin
                ir_we = 1'b1;
                pc_we = 1'b1;
            end
            EXE_R: alu_ctrl = is_subu ? 3'b001 : 3'b000;
            EXE_I: begin
                alu_src  = 1'b1;
                ext_sign = 1'b0;
                alu_ctrl = is_lui ? 3'b011 : 3'b010;
            end
            // ALU inputs stay as in the execute state so the result is stable at write.
            WB_ALU: begin
                reg_we = 1'b1;
                if (is_r) begin
                    reg_dst  = 2'b01;
                    alu_ctrl = is_subu ? 3'b001 : 3'b000;
                end else begin
                    alu_src  = 1'b1;
                    ext_sign = 1'b0;
                    alu_ctrl = is_lui ? 3'b011 : 3'b010;
                end
            end
            MEM_ADDR, MEM_RD, MEM_WR: begin
                alu_src = 1'b1;
                mem_re  = (cur == MEM_RD);
                mem_we  = (cur == MEM_WR);
            end
            WB_MEM: begin
                reg_we = 1'b1;
                wd_sel = 2'b01;
            end
            BR: begin
                alu_ctrl = 3'b001;
                if (zero) begin
                    pc_we   = 1'b1;
                    npc_sel = 2'b01;
                end
            end
            JMP: begin
                pc_we   = 1'b1;
                npc_sel = is_jr ? 2'b11 : 2'b10;
                if (is_jal) begin
                    reg_we  = 1'b1;
                    reg_dst = 2'b10;
                    wd_sel  = 2'b10;
                end
            end
            HALT:    illegal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class through its
// state sequence and checks controls, counter, halt and async reset behaviour.
module tb_multicycle_ctrl;

    logic        clk, reset, r2;
    logic [5:0]  op, func;
    logic        zero, mem_ready;
    logic [3:0]  state, state2;
    logic        ir_we, pc_we, reg_we, alu_src, ext_sign, mem_re, mem_we, illegal;
    logic [1:0]  npc_sel, reg_dst, wd_sel;
    logic [2:0]  alu_ctrl;
    logic [31:0] instr_cnt;
    logic        ir_we2, pc_we2, reg_we2, alu_src2, ext_sign2, mem_re2, mem_we2, illegal2;
    logic [1:0]  npc_sel2, reg_dst2, wd_sel2;
    logic [2:0]  alu_ctrl2;
    logic [1:0]  instr_cnt2;
    int          checks = 0;
    int          errors = 0;

    multicycle_ctrl #(.CNT_W(32), .HALT_ON_ILLEGAL(1'b1)) dut (
        .clk(clk), .reset(reset), .op(op), .func(func), .zero(zero), .mem_ready(mem_ready),
        .state(state), .ir_we(ir_we), .pc_we(pc_we), .npc_sel(npc_sel), .reg_we(reg_we),
        .reg_dst(reg_dst), .wd_sel(wd_sel), .alu_src(alu_src), .alu_ctrl(alu_ctrl),
        .ext_sign(ext_sign), .mem_re(mem_re), .mem_we(mem_we), .illegal(illegal),
        .instr_cnt(instr_cnt)
    );

    // Narrow counter, illegal-as-nop variant, exercised only in the last test.
    multicycle_ctrl #(.CNT_W(2), .HALT_ON_ILLEGAL(1'b0)) dut2 (
        .clk(clk), .reset(r2), .op(op), .func(func), .zero(zero), .mem_ready(mem_ready),
        .state(state2), .ir_we(ir_we2), .pc_we(pc_we2), .npc_sel(npc_sel2), .reg_we(reg_we2),
        .reg_dst(reg_dst2), .wd_sel(wd_sel2), .alu_src(alu_src2), .alu_ctrl(alu_ctrl2),
        .ext_sign(ext_sign2), .mem_re(mem_re2), .mem_we(mem_we2), .illegal(illegal2),
        .instr_cnt(instr_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; r2 = 1'b1; op = '0; func = '0; zero = 1'b0; mem_ready = 1'b0;
        #12;
        checks++;
        if ({state, illegal, instr_cnt} !== {4'd0, 1'b0, 32'd0}) begin
            errors++; $display("FAIL reset_state: got st=%0d ill=%0b cnt=%0d want st=0 ill=0 cnt=0", state, illegal, instr_cnt);
        end
        checks++;
        if ({ir_we, pc_we, npc_sel, reg_we, mem_re, mem_we} !== {1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL reset_fetch_ctl: got ir=%0b pc=%0b npc=%0b rw=%0b re=%0b we=%0b want 1 1 00 0 0 0",
                               ir_we, pc_we, npc_sel, reg_we, mem_re, mem_we);
        end
        reset = 1'b0;
    endtask

    task automatic test_addu;
        op = 6'b000000; func = 6'b100001;
        next_cycle();
        checks++;
        if ({state, reg_we} !== {4'd1, 1'b0}) begin
            errors++; $display("FAIL addu_decode: got st=%0d rw=%0b want st=1 rw=0", state, reg_we);
        end
        next_cycle();
        checks++;
        if ({state, alu_src, alu_ctrl, reg_we} !== {4'd2, 1'b0, 3'b000, 1'b0}) begin
            errors++; $display("FAIL addu_exe: got st=%0d src=%0b alu=%0b rw=%0b want st=2 src=0 alu=000 rw=0", state, alu_src, alu_ctrl, reg_we);
        end
        next_cycle();
        checks++;
        if ({state, reg_we, reg_dst, wd_sel, alu_ctrl} !== {4'd4, 1'b1, 2'b01, 2'b00, 3'b000}) begin
            errors++; $display("FAIL addu_wb: got st=%0d rw=%0b dst=%0b wd=%0b alu=%0b want st=4 rw=1 dst=01 wd=00 alu=000",
                               state, reg_we, reg_dst, wd_sel, alu_ctrl);
        end
        next_cycle();
        checks++;
        if ({state, instr_cnt} !== {4'd0, 32'd1}) begin
            errors++; $display("FAIL addu_retire: got st=%0d cnt=%0d want st=0 cnt=1", state, instr_cnt);
        end
    endtask

    task automatic test_lw_wait;
        int cycles;
        op = 6'b100011; func = 6'b000000; mem_ready = 1'b0;
        cycles = 1;
        next_cycle(); cycles++;
        next_cycle(); cycles++;
        checks++;
        if ({state, alu_src, alu_ctrl, ext_sign, reg_we} !== {4'd5, 1'b1, 3'b000, 1'b1, 1'b0}) begin
            errors++; $display("FAIL lw_addr: got st=%0d src=%0b alu=%0b ext=%0b rw=%0b want st=5 src=1 alu=000 ext=1 rw=0",
                               state, alu_src, alu_ctrl, ext_sign, reg_we);
        end
        for (int i = 0; i < 4; i++) begin
            next_cycle(); cycles++;
            mem_ready = (i == 3);
            #1;
            checks++;
            if ({state, mem_re, alu_src, reg_we} !== {4'd6, 1'b1, 1'b1, 1'b0}) begin
                errors++; $display("FAIL lw_memrd_%0d: got st=%0d re=%0b src=%0b rw=%0b want st=6 re=1 src=1 rw=0",
                                   i, state, mem_re, alu_src, reg_we);
            end
        end
        next_cycle(); cycles++;
        mem_ready = 1'b0;
        #1;
        checks++;
        if ({state, reg_we, reg_dst, wd_sel, mem_re} !== {4'd7, 1'b1, 2'b00, 2'b01, 1'b0}) begin
            errors++; $display("FAIL lw_wb: got st=%0d rw=%0b dst=%0b wd=%0b re=%0b want st=7 rw=1 dst=00 wd=01 re=0",
                               state, reg_we, reg_dst, wd_sel, mem_re);
        end
        next_cycle();
        checks++;
        if ({state, instr_cnt, cycles} !== {4'd0, 32'd2, 32'd8}) begin
            errors++; $display("FAIL lw_retire: got st=%0d cnt=%0d cycles=%0d want st=0 cnt=2 cycles=8", state, instr_cnt, cycles);
        end
    endtask

    task automatic test_beq;
        for (int k = 0; k < 2; k++) begin
            op = 6'b000100; func = 6'b000000; zero = (k == 0);
            next_cycle();
            next_cycle();
            checks++;
            if ({state, alu_src, alu_ctrl, pc_we, npc_sel} !== {4'd9, 1'b0, 3'b001, (k == 0), (k == 0) ? 2'b01 : 2'b00}) begin
                errors++; $display("FAIL beq_br_z%0d: got st=%0d src=%0b alu=%0b pc=%0b npc=%0b", 1 - k, state, alu_src, alu_ctrl, pc_we, npc_sel);
            end
            next_cycle();
        end
        zero = 1'b0;
        checks++;
        if ({state, instr_cnt} !== {4'd0, 32'd4}) begin
            errors++; $display("FAIL beq_retire: got st=%0d cnt=%0d want st=0 cnt=4", state, instr_cnt);
        end
    endtask

    task automatic test_jumps;
        op = 6'b000011; func = 6'b000000;
        next_cycle();
        next_cycle();
        checks++;
        if ({state, pc_we, npc_sel, reg_we, reg_dst, wd_sel} !== {4'd10, 1'b1, 2'b10, 1'b1, 2'b10, 2'b10}) begin
            errors++; $display("FAIL jal_jmp: got st=%0d pc=%0b npc=%0b rw=%0b dst=%0b wd=%0b want st=10 pc=1 npc=10 rw=1 dst=10 wd=10",
                               state, pc_we, npc_sel, reg_we, reg_dst, wd_sel);
        end
        next_cycle();
        op = 6'b000000; func = 6'b001000;
        next_cycle();
        next_cycle();
        checks++;
        if ({state, pc_we, npc_sel, reg_we} !== {4'd10, 1'b1, 2'b11, 1'b0}) begin
            errors++; $display("FAIL jr_jmp: got st=%0d pc=%0b npc=%0b rw=%0b want st=10 pc=1 npc=11 rw=0", state, pc_we, npc_sel, reg_we);
        end
        next_cycle();
        checks++;
        if ({state, instr_cnt} !== {4'd0, 32'd6}) begin
            errors++; $display("FAIL jump_retire: got st=%0d cnt=%0d want st=0 cnt=6", state, instr_cnt);
        end
    endtask

    task automatic test_ori_nop;
        op = 6'b001101; func = 6'b000000;
        next_cycle();
        next_cycle();
        checks++;
        if ({state, alu_src, ext_sign, alu_ctrl} !== {4'd3, 1'b1, 1'b0, 3'b010}) begin
            errors++; $display("FAIL ori_exe: got st=%0d src=%0b ext=%0b alu=%0b want st=3 src=1 ext=0 alu=010", state, alu_src, ext_sign, alu_ctrl);
        end
        next_cycle();
        checks++;
        if ({state, reg_we, reg_dst, alu_src, alu_ctrl} !== {4'd4, 1'b1, 2'b00, 1'b1, 3'b010}) begin
            errors++; $display("FAIL ori_wb: got st=%0d rw=%0b dst=%0b src=%0b alu=%0b want st=4 rw=1 dst=00 src=1 alu=010",
                               state, reg_we, reg_dst, alu_src, alu_ctrl);
        end
        next_cycle();
        op = 6'b000000; func = 6'b000000;
        next_cycle();
        checks++;
        if ({state, reg_we, pc_we} !== {4'd1, 1'b0, 1'b0}) begin
            errors++; $display("FAIL nop_decode: got st=%0d rw=%0b pc=%0b want st=1 rw=0 pc=0", state, reg_we, pc_we);
        end
        next_cycle();
        checks++;
        if ({state, instr_cnt} !== {4'd0, 32'd8}) begin
            errors++; $display("FAIL nop_retire: got st=%0d cnt=%0d want st=0 cnt=8", state, instr_cnt);
        end
    endtask

    task automatic test_illegal;
        op = 6'b111111; func = 6'b000000;
        next_cycle();
        for (int i = 0; i < 20; i++) begin
            next_cycle();
            checks++;
            if ({state, illegal, pc_we, ir_we, reg_we, instr_cnt} !== {4'd11, 1'b1, 1'b0, 1'b0, 1'b0, 32'd8}) begin
                errors++; $display("FAIL halt_hold_%0d: got st=%0d ill=%0b pc=%0b ir=%0b rw=%0b cnt=%0d want st=11 ill=1 0 0 0 cnt=8",
                                   i, state, illegal, pc_we, ir_we, reg_we, instr_cnt);
            end
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({state, illegal, instr_cnt} !== {4'd0, 1'b0, 32'd0}) begin
            errors++; $display("FAIL halt_async_reset: got st=%0d ill=%0b cnt=%0d want st=0 ill=0 cnt=0", state, illegal, instr_cnt);
        end
        #1;
        reset = 1'b0;
    endtask

    task automatic test_sw_reset;
        op = 6'b101011; func = 6'b000000; mem_ready = 1'b0;
        next_cycle();
        next_cycle();
        next_cycle();
        mem_ready = 1'b1;
        #1;
        checks++;
        if ({state, mem_we, mem_re, alu_src, ext_sign} !== {4'd8, 1'b1, 1'b0, 1'b1, 1'b1}) begin
            errors++; $display("FAIL sw_memwr: got st=%0d we=%0b re=%0b src=%0b ext=%0b want st=8 we=1 re=0 src=1 ext=1",
                               state, mem_we, mem_re, alu_src, ext_sign);
        end
        next_cycle();
        mem_ready = 1'b0;
        checks++;
        if ({state, mem_we, instr_cnt} !== {4'd0, 1'b0, 32'd1}) begin
            errors++; $display("FAIL sw_retire: got st=%0d we=%0b cnt=%0d want st=0 we=0 cnt=1", state, mem_we, instr_cnt);
        end
        next_cycle();
        next_cycle();
        next_cycle();
        next_cycle();
        checks++;
        if ({state, mem_we} !== {4'd8, 1'b1}) begin
            errors++; $display("FAIL sw_wait: got st=%0d we=%0b want st=8 we=1", state, mem_we);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({state, mem_we, reg_we, instr_cnt} !== {4'd0, 1'b0, 1'b0, 32'd0}) begin
            errors++; $display("FAIL sw_async_reset: got st=%0d we=%0b rw=%0b cnt=%0d want st=0 we=0 rw=0 cnt=0",
                               state, mem_we, reg_we, instr_cnt);
        end
        #1;
        reset = 1'b0;
        next_cycle();
        checks++;
        if ({state, instr_cnt} !== {4'd1, 32'd0}) begin
            errors++; $display("FAIL sw_after_reset: got st=%0d cnt=%0d want st=1 cnt=0", state, instr_cnt);
        end
    endtask

    task automatic test_nohalt_wrap;
        reset = 1'b1;
        op = 6'b111111; func = 6'b000000;
        #1;
        r2 = 1'b0;
        next_cycle();
        next_cycle();
        checks++;
        if ({state2, illegal2, instr_cnt2} !== {4'd0, 1'b0, 2'd1}) begin
            errors++; $display("FAIL nohalt_illegal: got st=%0d ill=%0b cnt=%0d want st=0 ill=0 cnt=1", state2, illegal2, instr_cnt2);
        end
        op = 6'b000000;
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            next_cycle();
            checks++;
            if ({state2, instr_cnt2} !== {4'd0, 2'(k + 2)}) begin
                errors++; $display("FAIL wrap_cnt_%0d: got st=%0d cnt=%0d want st=0 cnt=%0d", k, state2, instr_cnt2, (k + 2) % 4);
            end
        end
    endtask

    initial begin
        test_reset();
        test_addu();
        test_lw_wait();
        test_beq();
        test_jumps();
        test_ori_nop();
        test_illegal();
        test_sw_reset();
        test_nohalt_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multicycle control FSM that sequences the MIPS datapath (PC, IM, GRF, EXT, ALU, DM, NPC) over several cycles per instruction instead of one.
- Decodes op/func from the instruction register.
- Steps through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states, stalling on data-memory handshake.
- Drives every datapath enable and mux select.
- Counts retired instructions.
- Halts on an unsupported encoding.

Parameters:
CNT_W, 32, width of retired-instruction counter (wraps modulo 2^CNT_W)
HALT_ON_ILLEGAL, 1, 1: illegal encoding enters HALT; 0: treated as nop

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
op  input  6  IR[31:26]
func  input  6  IR[5:0]
zero  input  1  ALU zero flag
mem_ready  input  1  data memory done this cycle
state  output  4  current state encoding
ir_we  output  1  load instruction register
pc_we  output  1  load PC from NPC
npc_sel  output  2  00 PC+4, 01 branch, 10 j/jal target, 11 rs (jr)
reg_we  output  1  GRF write enable
reg_dst  output  2  00 rt, 01 rd, 10 $31
wd_sel  output  2  00 ALU result, 01 memory data, 10 PC (already PC+4)
alu_src  output  1  0 rt data, 1 extended imm
alu_ctrl  output  3  000 add, 001 sub, 010 or, 011 lui (imm<<16)
ext_sign  output  1  1 sign-extend, 0 zero-extend
mem_re  output  1  data memory read request
mem_we  output  1  data memory write request
illegal  output  1  high in HALT
instr_cnt  output  CNT_W  retired instructions

Behaviour:
- Reset (async, any state): state=FETCH(0), instr_cnt=0, illegal=0.
- All outputs are combinational from state/op/func/zero.
- Every enable defaults to 0; selects default to 00; alu_ctrl defaults to 000; ext_sign defaults to 1.
- Decode:
  - R-type (op 000000): addu func 100001, subu func 100011, jr func 001000, nop func 000000.
  - I/J-type: ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
  - Anything else is illegal.
- State encodings: FETCH 0, DECODE 1, EXE_R 2, EXE_I 3, WB_ALU 4, MEM_ADDR 5, MEM_RD 6, WB_MEM 7, MEM_WR 8, BR 9, JMP 10, HALT 11.
- FETCH:
  - Asserts ir_we=1, pc_we=1, npc_sel=00.
  - Next state is DECODE.
- DECODE:
  - addu/subu → EXE_R; ori/lui → EXE_I; lw/sw → MEM_ADDR; beq → BR; j/jal/jr → JMP.
  - nop → FETCH (retires).
  - illegal → HALT, or FETCH (retires) if HALT_ON_ILLEGAL=0.
- EXE_R:
  - alu_src=0; alu_ctrl=000 for addu, 001 for subu.
  - Next state is WB_ALU.
- EXE_I:
  - alu_src=1; ext_sign=0.
  - alu_ctrl=010 for ori, 011 for lui.
  - Next state is WB_ALU.
- WB_ALU:
  - reg_we=1, wd_sel=00.
  - reg_dst=01 for R-type, 00 otherwise.
  - ALU controls held as in the EXE state.
  - Next state is FETCH (retire).
- MEM_ADDR:
  - alu_src=1, alu_ctrl=000, ext_sign=1.
  - Next state is MEM_RD for lw, MEM_WR for sw.
- MEM_RD:
  - mem_re=1 with address controls held.
  - Stays while mem_ready=0; moves to WB_MEM on mem_ready=1.
- WB_MEM:
  - reg_we=1, reg_dst=00, wd_sel=01.
  - Next state is FETCH (retire).
- MEM_WR:
  - mem_we=1 with address controls held every cycle in the state.
  - Stays while mem_ready=0; on mem_ready=1 goes to FETCH (retire).
- BR:
  - alu_src=0, alu_ctrl=001.
  - If zero=1: pc_we=1, npc_sel=01.
  - Next state is FETCH (retire) regardless of zero.
- JMP:
  - pc_we=1; npc_sel=11 for jr, 10 otherwise.
  - jal additionally asserts reg_we=1, reg_dst=10, wd_sel=10 in the same cycle; the PC register still holds PC+4 at that point.
  - Next state is FETCH (retire).
- HALT:
  - illegal=1, all enables 0.
  - Stays in HALT until reset.
- instr_cnt increments by 1 on each clock edge that leaves a state for FETCH (retire). It wraps at 2^CNT_W.
- Cycle counts: nop 2, beq/j/jr/jal 3, addu/subu/ori/lui 4, sw 4+waits, lw 5+waits.
- Reset asserted mid-instruction: next cycle is FETCH, no partial write is issued, counter is 0.

Test Plan:
- Reset, then addu (op 0, func 100001) → state sequence 0,1,2,4,0; reg_we=1 only in state 4 with reg_dst=01; instr_cnt=1.
- lw with mem_ready low 3 cycles → MEM_RD held 4 cycles with mem_re=1; WB_MEM has reg_we=1, wd_sel=01; total 8 cycles; no reg_we before WB_MEM.
- beq with zero=1, then beq with zero=0 → pc_we=1, npc_sel=01 in BR only for the first; both retire, instr_cnt += 2.
- jal → JMP cycle shows pc_we=1, npc_sel=10, reg_we=1, reg_dst=10, wd_sel=10; jr → npc_sel=11, reg_we=0.
- op=111111 with HALT_ON_ILLEGAL=1 → state 11, illegal=1, holds for 20 cycles; async reset mid-cycle → state 0, illegal=0, instr_cnt=0 before next edge.
- sw with reset asserted during MEM_WR wait → mem_we drops immediately; after reset, FETCH with instr_cnt=0.
